// File: rtl/tick_sched_ctrl.sv
// Run-control and configuration controller for a divide-by-N tick generator.
// Divisor updates made while running are deferred to a period boundary.
module tick_sched_ctrl #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DEFAULT_DIV = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_burst,
  input  logic             start,
  input  logic             stop,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cur_div
);

  localparam logic [CNT_W-1:0] One    = CNT_W'(1);
  localparam logic [CNT_W-1:0] DefDiv = CNT_W'(DEFAULT_DIV);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           r_state,      w_state_nxt;
  logic [CNT_W-1:0] r_cnt,        w_cnt_nxt;
  logic [CNT_W-1:0] r_burst_rem,  w_burst_rem_nxt;
  logic [CNT_W-1:0] r_div,        w_div_nxt;
  logic [CNT_W-1:0] r_burst,      w_burst_nxt;
  logic             r_pend_valid, w_pend_valid_nxt;
  logic [CNT_W-1:0] r_pend_div,   w_pend_div_nxt;
  logic [CNT_W-1:0] r_pend_burst, w_pend_burst_nxt;

  logic             w_xfer;
  logic             w_wrap;
  logic [CNT_W-1:0] w_cfg_div;

  assign busy      = (r_state == StRun);
  assign tick      = busy && (r_cnt == '0);
  // Stop on the final burst tick still ends the run, but it is an abort, not a completion.
  assign done      = tick && (r_burst != '0) && (r_burst_rem == One) && !stop;
  assign cfg_ready = (r_state == StIdle) || !r_pend_valid;
  assign cur_div   = r_div;

  assign w_xfer    = cfg_valid && cfg_ready;
  assign w_wrap    = (r_cnt == (r_div - One));
  assign w_cfg_div = (cfg_div == '0) ? One : cfg_div;

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_burst_rem_nxt  = r_burst_rem;
    w_div_nxt        = r_div;
    w_burst_nxt      = r_burst;
    w_pend_valid_nxt = r_pend_valid;
    w_pend_div_nxt   = r_pend_div;
    w_pend_burst_nxt = r_pend_burst;

    unique case (r_state)
      StIdle: begin
        if (w_xfer) begin
          w_div_nxt   = w_cfg_div;
          w_burst_nxt = cfg_burst;
        end
        if (start && !stop) begin
          w_state_nxt     = StRun;
          w_cnt_nxt       = '0;
          w_burst_rem_nxt = r_burst;
        end
      end
      StRun: begin
        if (stop || done) begin
          w_state_nxt      = StIdle;
          w_cnt_nxt        = '0;
          w_pend_valid_nxt = 1'b0;
          // A request accepted in the exit cycle itself lands directly in the active config.
          if (r_pend_valid) begin
            w_div_nxt   = r_pend_div;
            w_burst_nxt = r_pend_burst;
          end else if (w_xfer) begin
            w_div_nxt   = w_cfg_div;
            w_burst_nxt = cfg_burst;
          end
        end else begin
          w_cnt_nxt = w_wrap ? '0 : r_cnt + One;
          if (tick && (r_burst != '0) && (r_burst_rem > One)) begin
            w_burst_rem_nxt = r_burst_rem - One;
          end
          if (w_wrap && r_pend_valid) begin
            w_div_nxt        = r_pend_div;
            w_burst_nxt      = r_pend_burst;
            w_pend_valid_nxt = 1'b0;
          end else if (w_xfer) begin
            w_pend_div_nxt   = w_cfg_div;
            w_pend_burst_nxt = cfg_burst;
            w_pend_valid_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_burst_rem  <= '0;
      r_div        <= DefDiv;
      r_burst      <= '0;
      r_pend_valid <= 1'b0;
      r_pend_div   <= '0;
      r_pend_burst <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_burst_rem  <= w_burst_rem_nxt;
      r_div        <= w_div_nxt;
      r_burst      <= w_burst_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      r_pend_div   <= w_pend_div_nxt;
      r_pend_burst <= w_pend_burst_nxt;
    end
  end

endmodule

// File: tb/tb_tick_sched_ctrl.sv
// Directed vector bench for tick_sched_ctrl: per-cycle table plus a reset-abort sequence.
module tb_tick_sched_ctrl;

  logic       clk;
  logic       reset_n;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_div;
  logic [7:0] cfg_burst;
  logic       start;
  logic       stop;
  logic       tick;
  logic       busy;
  logic       done;
  logic [7:0] cur_div;

  int checks   = 0;
  int failures = 0;

  tick_sched_ctrl #(
    .CNT_W      (8),
    .DEFAULT_DIV(3)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_div  (cfg_div),
    .cfg_burst(cfg_burst),
    .start    (start),
    .stop     (stop),
    .tick     (tick),
    .busy     (busy),
    .done     (done),
    .cur_div  (cur_div)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Inputs driven during a cycle and outputs expected in that same cycle.
  // exp packs {tick, busy, done, cfg_ready, cur_div}.
  typedef struct {
    logic       cv;
    logic [7:0] cd;
    logic [7:0] cb;
    logic       st;
    logic       sp;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int cv, input int cd, input int cb, input int st,
                              input int sp, input int t, input int b, input int d,
                              input int r, input int cur);
    vec_t v;
    v.cv  = cv[0];
    v.cd  = cd[7:0];
    v.cb  = cb[7:0];
    v.st  = st[0];
    v.sp  = sp[0];
    v.exp = {t[0], b[0], d[0], r[0], cur[7:0]};
    return v;
  endfunction

  task automatic check_out(input string name, input logic [11:0] exp);
    logic [11:0] got;
    got = {tick, busy, done, cfg_ready, cur_div};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got tick/busy/done/ready/div=%b/%b/%b/%b/%0d required %b/%b/%b/%b/%0d",
               name, got[11], got[10], got[9], got[8], got[7:0],
               exp[11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    @(negedge clk);
    cfg_valid = v.cv;
    cfg_div   = v.cd;
    cfg_burst = v.cb;
    start     = v.st;
    stop      = v.sp;
    #1;
    check_out(name, v.exp);
  endtask

  initial begin
    reset_n   = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    cfg_burst = '0;
    start     = 1'b0;
    stop      = 1'b0;

    // Defaults, continuous: ticks at 1,4,7,10
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 1, 3));
    for (int i = 2; i <= 10; i++) begin
      vecs.push_back(mk(0, 0, 0, 0, 0, (i % 3 == 1) ? 1 : 0, 1, 0, 1, 3));
    end
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 1, 3));
    vecs.push_back(mk(1, 4, 3, 0, 0, 0, 0, 0, 1, 3));
    // div=4 burst=3: ticks 1,5,9, done at 9
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 4));
    for (int i = 1; i <= 8; i++) begin
      vecs.push_back(mk(0, 0, 0, 0, 0, (i % 4 == 1) ? 1 : 0, 1, 0, 1, 4));
    end
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 1, 4));
    vecs.push_back(mk(1, 0, 2, 0, 0, 0, 0, 0, 1, 4));
    // div=0 -> 1, burst=2: ticks 1,2, done at 2
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 1, 1));
    vecs.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0, 1, 1));
    // start && stop in IDLE stays IDLE
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 1, 3));
    // Continuous div=3, deferred change to 5 accepted at cycle 5
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 1, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 1, 3));
    vecs.push_back(mk(1, 5, 0, 0, 0, 0, 1, 0, 1, 3));
    vecs.push_back(mk(1, 7, 0, 0, 0, 0, 1, 0, 0, 3));
    for (int i = 7; i <= 17; i++) begin
      vecs.push_back(mk(0, 0, 0, 0, 0, (i % 5 == 2) ? 1 : 0, 1, 0, 1, 5));
    end
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 1, 5));
    vecs.push_back(mk(1, 3, 5, 0, 0, 0, 0, 0, 1, 5));
    // div=3 burst=5: start in RUN ignored, stop in tick cycle 4 with cfg in the exit cycle
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 1, 3));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 1, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 3));
    vecs.push_back(mk(1, 2, 1, 0, 1, 1, 1, 0, 1, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2));
    // burst=1: stop on the final tick suppresses done
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 2));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 1, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2));

    @(negedge clk);
    #1;
    check_out("reset_values", {4'b0001, 8'd3});
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec[%0d]", i));
    end

    // Restore defaults, queue a pending divisor, then abort with reset mid-period.
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    apply(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 3), "rst_seq_start");
    apply(mk(0, 0, 0, 0, 0, 1, 1, 0, 1, 3), "rst_seq_tick1");
    apply(mk(1, 6, 0, 0, 0, 0, 1, 0, 1, 3), "rst_seq_cfg");
    apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 3), "rst_seq_pending");
    #2;
    reset_n = 1'b0;
    #1;
    check_out("async_reset_abort", {4'b0001, 8'd3});
    @(negedge clk);
    reset_n = 1'b1;
    apply(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 3), "post_rst_start");
    apply(mk(0, 0, 0, 0, 0, 1, 1, 0, 1, 3), "post_rst_c1");
    apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 3), "post_rst_c2");
    apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 3), "post_rst_c3");
    apply(mk(0, 0, 0, 0, 0, 1, 1, 0, 1, 3), "post_rst_c4");
    apply(mk(0, 0, 0, 0, 1, 0, 1, 0, 1, 3), "post_rst_stop");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 3), "post_rst_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tick_sched_ctrl.md
Name: tick_sched_ctrl

Overview:
- Run-control and configuration controller for the team's divide-by-N state-machine datapath.
- Sequences a programmable divide-by-N counter that emits a one-cycle tick every N clocks.
- Supports start/stop control, finite-burst or continuous operation, and a valid/ready configuration port.
- Divisor changes requested while running are applied only at a period boundary, so downstream logic never sees a truncated period.

Parameters:
- CNT_W, 8, width of divisor, burst and internal counters.
- DEFAULT_DIV, 3, divisor loaded at reset; must be 1..2^CNT_W-1.

Ports:
- clk  in  1  sole clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  configuration port can accept this cycle.
- cfg_div  in  CNT_W  requested divisor; 0 is treated as 1.
- cfg_burst  in  CNT_W  tick count per run; 0 means continuous.
- start  in  1  begin a run (level-sampled, one cycle sufficient).
- stop  in  1  abort a run.
- tick  out  1  one-cycle pulse, period = active divisor.
- busy  out  1  high while state is RUN.
- done  out  1  one-cycle pulse coinciding with the final tick of a finite burst.
- cur_div  out  CNT_W  active divisor (div_reg).

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (reset_n).
- Reset values:
  - state=IDLE, cnt=0, burst_rem=0, pend_valid=0.
  - div_reg=DEFAULT_DIV, burst_reg=0.
  - tick=0, busy=0, done=0, cfg_ready=1, cur_div=DEFAULT_DIV.
- Reset asserted mid-run aborts immediately, with no done pulse.
- States:
  - IDLE: busy=0, tick=0.
  - IDLE->RUN on start && !stop. Next edge: cnt<=0, burst_rem<=burst_reg.
  - RUN: busy=1. tick = (cnt==0), Moore, so tick is registered-state derived.
  - RUN: cnt <= (cnt==div_reg-1) ? 0 : cnt+1.
  - RUN->IDLE on stop (stop wins over all RUN activity).
  - RUN->IDLE on done.
- Latency and periods:
  - First tick in the first RUN cycle, i.e. 1 cycle after start is sampled.
  - Subsequent ticks every div_reg cycles.
  - div_reg=1 gives tick every RUN cycle.
- Burst:
  - If burst_reg!=0, burst_rem decrements on each tick.
  - done = tick && burst_reg!=0 && burst_rem==1. Next cycle is IDLE.
  - burst_reg==0: runs until stop; done never asserts.
- Config handshake: transfer occurs when cfg_valid && cfg_ready.
  - IDLE: cfg_ready=1. div_reg <= max(cfg_div,1) and burst_reg <= cfg_burst on the next edge.
  - RUN: cfg_ready = !pend_valid. An accepted request is held in pend_div/pend_burst with pend_valid=1.
  - Pending request is applied at the wrap edge (cnt==div_reg-1): div_reg and burst_reg update, pend_valid clears. The period beginning with the next tick uses the new divisor.
  - burst_rem is not reloaded; a new burst count takes effect on the next start.
  - On a RUN->IDLE transition with pend_valid=1, the pending values are applied at that edge.
  - A transfer in the same cycle as RUN->IDLE is captured as pending and applied at that edge.
- Simultaneous events:
  - start in RUN is ignored.
  - start && stop in IDLE: stays IDLE.
  - stop in a tick cycle: tick still asserts (Moore); done is suppressed; IDLE next cycle.
  - stop and the final burst tick together: done is suppressed.
- Arithmetic:
  - cnt and burst_rem are unsigned CNT_W. No wrap can occur: cnt is bounded by div_reg-1, and burst_rem stops at 1.

Test Plan:
1. Release reset, pulse start at cycle 0 (defaults) -> busy=1 from cycle 1; tick at cycles 1,4,7,10; done never asserts; cur_div=3.
2. IDLE cfg div=4, burst=3; start at cycle 0 -> ticks at 1,5,9; done=1 at cycle 9 only; busy=0 from cycle 10.
3. Continuous run at div=3 (ticks 1,4); cfg div=5 accepted at cycle 5 (cfg_ready falls) -> next tick 7; then ticks 12,17; cfg_ready=1 from cycle 7.
4. cfg div=0, burst=2, start -> cur_div=1; ticks at cycles 1,2; done at 2; IDLE at 3.
5. Running div=3 with burst=5; stop asserted in tick cycle 4 -> tick=1 at 4, done=0, busy=0 at 5; a start in a RUN cycle is ignored.
6. Running with a pending cfg; drop reset_n mid-period -> tick, busy and done go 0 without a clock edge; cur_div=3; pend_valid is cleared, so the pending divisor is never applied.
